rpn_lan_rx: RTL and testbench
=============================

RPN_LAN_RX -- requirements
Module: rpn_lan_rx

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- `NODE_ID_WIDTH`, 8, node ID bits.
- `LAN_SEQUENCE_NUMBER_WIDTH`, 32, sequence number bits.
- `AXIS_DATA_WIDTH`, 512, TDATA bits.
- `BRAM_ADDR_WIDTH`, 32, BRAM byte address bits.
- Field offsets/widths SHALL come from the shared ctrl_api header/message parameter includes.

REQ-002 Ports, one per line (name, direction, width, meaning):
- `i_clk`, in, 1, sole clock.
- `i_ap_rst_n`, in, 1, asynchronous active-low reset.
- `i_node_id`, in, `NODE_ID_WIDTH`, own node ID.
- `i_sequence_numbers_initialized`, in, 1, BRAM contents valid.
- `from_nb_LAN_{tvalid,tready,tdata,tkeep,tid,tdest,tuser,tlast}`, in (tready out), AXIS, LAN packets from Network Bridge.
- `to_app_{tvalid,tready,tdata,tkeep,tid,tdest,tuser,tlast}`, out (tready in), AXIS, delivered PUB payloads.
- `to_nb_ack_{tvalid,tready,tdata,tkeep,tdest,tuser,tlast}`, out (tready in), AXIS, LAN ACK to sender.
- `rx_seq_num_BRAM_{CLK,RST,EN,ADDR,DIN,WEN}`, out, last accepted sequence number per sender.
- `rx_seq_num_BRAM_DOUT`, in, `LAN_SEQUENCE_NUMBER_WIDTH`, read data, 1-cycle read latency.

Function
REQ-003 The FSM states SHALL be INIT, IDLE, READ_SEQ, CHECK, DELIVER, SEND_ACK.
- INIT→IDLE when `i_sequence_numbers_initialized`=1.
- IDLE→READ_SEQ on `from_nb_LAN_tvalid`=1 with msg type `RPN_MSG_TYPE_LAN_PUB`.
- READ_SEQ→CHECK unconditionally.

REQ-004 `from_nb_LAN_tready` SHALL be 1 only in IDLE.
- Non-PUB beats accepted in IDLE SHALL be discarded, with no state change.

REQ-005 On PUB acceptance, the block SHALL register:
- sender ID, sequence number, payload (`PUB_LAN_DATA` field), tkeep, tid and tdest;
- and SHALL assert BRAM EN with ADDR = sender ID << 2 (bits[1:0]=0, upper bits 0).

REQ-006 In CHECK, the block SHALL compute diff = rx_seq − DOUT modulo 2^`LAN_SEQUENCE_NUMBER_WIDTH` and act as follows:
- diff==1 (new): go to DELIVER.
- diff==0 or diff MSB=1 (duplicate): go to SEND_ACK, without delivery and without a BRAM write.
- Otherwise (gap): drop the packet, send no ACK, return to IDLE.

REQ-007 DELIVER SHALL hold `to_app_tvalid`=1 with stable registered payload/tkeep/tid/tdest, tuser=1, tlast=1, and SHALL move to SEND_ACK on `to_app_tready`=1.

REQ-008 SEND_ACK SHALL hold `to_nb_ack_tvalid`=1 with the following fields:
- msg type `RPN_MSG_TYPE_LAN_ACK`;
- `LAN_ACK_SENDER_NODE_ID` = `i_node_id`;
- `LAN_ACK_SEQUENCE_NUMBER` = rx_seq;
- tdest = sender ID, tkeep = all ones, tuser=1, tlast=1;
- and SHALL go to IDLE on `to_nb_ack_tready`.

REQ-009 For new packets only, the BRAM write (EN=1, WEN=4'hF, DIN=rx_seq, ADDR=sender<<2) SHALL occur in the SEND_ACK handshake cycle.
- EN, WEN and DIN SHALL be 0 in all other cycles.

REQ-010 Sequence wrap SHALL be treated as follows:
- rx_seq=0 with stored all-ones SHALL be new.
- Stored value 0 with rx_seq=all-ones SHALL be duplicate.

REQ-011 Latency from PUB acceptance to `to_app_tvalid` SHALL be 3 cycles.
- The block SHALL process one packet at a time, with no pipelining across packets.

REQ-012 `rx_seq_num_BRAM_CLK` SHALL equal `i_clk`, and `rx_seq_num_BRAM_RST` SHALL equal `~i_ap_rst_n`.

Reset
REQ-013 On `i_ap_rst_n`=0 the block SHALL asynchronously enter INIT and clear all registers.
- All tvalid/tready SHALL be 0, BRAM EN/WEN/DIN/ADDR SHALL be 0, and data outputs SHALL be 0.

REQ-014 Reset mid-DELIVER or mid-SEND_ACK SHALL abandon the packet without a BRAM write.
- After INIT exit, the block SHALL resume in IDLE.

REQ-015 While in INIT, `from_nb_LAN_tready` SHALL be 0 regardless of input.

Verification
REQ-016 Stored seq[3]=7; PUB from node 3 with seq 8 → one `to_app` beat with the payload, then an ACK (seq 8, tdest 3), and BRAM[0xC]=8.

REQ-017 Stored seq[3]=8; PUB seq 8 re-sent → ACK seq 8, no `to_app` beat, no BRAM write.

REQ-018 Stored seq[3]=8; PUB seq 10 → no ACK, no delivery, no write, back to IDLE.

REQ-019 Stored seq[5]=0xFFFFFFFF; PUB seq 0 → delivered, ACK seq 0, BRAM[0x14]=0.

REQ-020 `to_app_tready` held 0 for 20 cycles, then 1 → tvalid/data stable throughout, ACK only after the handshake.

REQ-021 Assert reset during SEND_ACK → outputs 0 immediately, no BRAM write, INIT until initialized=1.

Source files
------------

// File: rtl/rpn_lan_rx.sv
// rpn_lan_rx
//   Receives LAN PUB messages from the Network Bridge, checks each one against
//   the last accepted sequence number held in an external BRAM (one word per
//   sender), delivers new payloads to the application, and returns a LAN ACK
//   for both new and duplicate packets. Out-of-order (gap) packets are dropped
//   silently so the sender retransmits.
// Ports
//   i_clk, i_ap_rst_n            : clock, async active-low reset
//   i_node_id                    : own node ID, placed in ACK messages
//   i_sequence_numbers_initialized : BRAM contents are valid, leave INIT
//   from_nb_LAN_*                : AXIS input, LAN packets (tready out)
//   to_app_*                     : AXIS output, delivered PUB payloads
//   to_nb_ack_*                  : AXIS output, LAN ACK to the sender
//   rx_seq_num_BRAM_*            : per-sender sequence number BRAM port
module rpn_lan_rx #(
   parameter int NODE_ID_WIDTH             = 8,
   parameter int LAN_SEQUENCE_NUMBER_WIDTH = 32,
   parameter int AXIS_DATA_WIDTH           = 512,
   parameter int BRAM_ADDR_WIDTH           = 32
) (
   input  logic                                 i_clk,
   input  logic                                 i_ap_rst_n,
   input  logic [NODE_ID_WIDTH-1:0]             i_node_id,
   input  logic                                 i_sequence_numbers_initialized,
   input  logic                                 from_nb_LAN_tvalid,
   output logic                                 from_nb_LAN_tready,
   input  logic [AXIS_DATA_WIDTH-1:0]           from_nb_LAN_tdata,
   input  logic [AXIS_DATA_WIDTH/8-1:0]         from_nb_LAN_tkeep,
   input  logic [NODE_ID_WIDTH-1:0]             from_nb_LAN_tid,
   input  logic [NODE_ID_WIDTH-1:0]             from_nb_LAN_tdest,
   input  logic                                 from_nb_LAN_tuser,
   input  logic                                 from_nb_LAN_tlast,
   output logic                                 to_app_tvalid,
   input  logic                                 to_app_tready,
   output logic [AXIS_DATA_WIDTH-1:0]           to_app_tdata,
   output logic [AXIS_DATA_WIDTH/8-1:0]         to_app_tkeep,
   output logic [NODE_ID_WIDTH-1:0]             to_app_tid,
   output logic [NODE_ID_WIDTH-1:0]             to_app_tdest,
   output logic                                 to_app_tuser,
   output logic                                 to_app_tlast,
   output logic                                 to_nb_ack_tvalid,
   input  logic                                 to_nb_ack_tready,
   output logic [AXIS_DATA_WIDTH-1:0]           to_nb_ack_tdata,
   output logic [AXIS_DATA_WIDTH/8-1:0]         to_nb_ack_tkeep,
   output logic [NODE_ID_WIDTH-1:0]             to_nb_ack_tdest,
   output logic                                 to_nb_ack_tuser,
   output logic                                 to_nb_ack_tlast,
   output logic                                 rx_seq_num_BRAM_CLK,
   output logic                                 rx_seq_num_BRAM_RST,
   output logic                                 rx_seq_num_BRAM_EN,
   output logic [BRAM_ADDR_WIDTH-1:0]           rx_seq_num_BRAM_ADDR,
   output logic [LAN_SEQUENCE_NUMBER_WIDTH-1:0] rx_seq_num_BRAM_DIN,
   output logic [3:0]                           rx_seq_num_BRAM_WEN,
   input  logic [LAN_SEQUENCE_NUMBER_WIDTH-1:0] rx_seq_num_BRAM_DOUT
);

   // ctrl_api message layout (shared with the Network Bridge and senders)
   localparam int          MSG_TYPE_OFF                = 0;
   localparam int          MSG_TYPE_W                  = 8;
   localparam logic [7:0]  RPN_MSG_TYPE_LAN_PUB        = 8'h10;
   localparam logic [7:0]  RPN_MSG_TYPE_LAN_ACK        = 8'h11;
   localparam int          PUB_LAN_SENDER_NODE_ID_OFF  = MSG_TYPE_OFF + MSG_TYPE_W;
   localparam int          PUB_LAN_SEQUENCE_NUMBER_OFF = PUB_LAN_SENDER_NODE_ID_OFF + NODE_ID_WIDTH;
   localparam int          PUB_LAN_DATA_OFF            = 64;
   localparam int          LAN_ACK_SENDER_NODE_ID_OFF  = MSG_TYPE_OFF + MSG_TYPE_W;
   localparam int          LAN_ACK_SEQUENCE_NUMBER_OFF = LAN_ACK_SENDER_NODE_ID_OFF + NODE_ID_WIDTH;
   localparam int          SEQ_W                       = LAN_SEQUENCE_NUMBER_WIDTH;

   typedef enum logic [2:0] {INIT, IDLE, READ_SEQ, CHECK, DELIVER, SEND_ACK} state_t;

   state_t                        r_state;
   logic                          r_lan_tready;
   logic [NODE_ID_WIDTH-1:0]      r_sender;
   logic [SEQ_W-1:0]              r_rx_seq;
   logic [AXIS_DATA_WIDTH-1:0]    r_app_tdata;
   logic [AXIS_DATA_WIDTH/8-1:0]  r_app_tkeep;
   logic [NODE_ID_WIDTH-1:0]      r_app_tid;
   logic [NODE_ID_WIDTH-1:0]      r_app_tdest;
   logic                          r_app_tvalid;
   logic                          r_ack_tvalid;
   logic [AXIS_DATA_WIDTH-1:0]    r_ack_tdata;
   logic                          r_bram_rd_en;
   logic [BRAM_ADDR_WIDTH-1:0]    r_bram_addr;
   logic                          r_new;

   logic [MSG_TYPE_W-1:0]         w_in_type;
   logic [NODE_ID_WIDTH-1:0]      w_in_sender;
   logic [SEQ_W-1:0]              w_in_seq;
   logic [SEQ_W-1:0]              w_diff;
   logic [AXIS_DATA_WIDTH-1:0]    w_ack_tdata;
   logic                          w_bram_wr;
   logic                          w_unused;

   assign w_in_type   = from_nb_LAN_tdata[MSG_TYPE_OFF +: MSG_TYPE_W];
   assign w_in_sender = from_nb_LAN_tdata[PUB_LAN_SENDER_NODE_ID_OFF +: NODE_ID_WIDTH];
   assign w_in_seq    = from_nb_LAN_tdata[PUB_LAN_SEQUENCE_NUMBER_OFF +: SEQ_W];
   // Modular distance from the stored sequence number: 1 = next in order,
   // 0 or "negative" = already seen, anything else = packets were lost.
   assign w_diff      = r_rx_seq - rx_seq_num_BRAM_DOUT;
   assign w_unused    = ^{from_nb_LAN_tuser, from_nb_LAN_tlast, from_nb_LAN_tdata};

   always_comb begin
      w_ack_tdata = '0;
      w_ack_tdata[MSG_TYPE_OFF +: MSG_TYPE_W]                 = RPN_MSG_TYPE_LAN_ACK;
      w_ack_tdata[LAN_ACK_SENDER_NODE_ID_OFF +: NODE_ID_WIDTH] = i_node_id;
      w_ack_tdata[LAN_ACK_SEQUENCE_NUMBER_OFF +: SEQ_W]        = r_rx_seq;
   end

   always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
      if (!i_ap_rst_n) begin
         r_state      <= INIT;
         r_lan_tready <= 1'b0;
         r_sender     <= '0;
         r_rx_seq     <= '0;
         r_app_tdata  <= '0;
         r_app_tkeep  <= '0;
         r_app_tid    <= '0;
         r_app_tdest  <= '0;
         r_app_tvalid <= 1'b0;
         r_ack_tvalid <= 1'b0;
         r_ack_tdata  <= '0;
         r_bram_rd_en <= 1'b0;
         r_bram_addr  <= '0;
         r_new        <= 1'b0;
      end else begin
         r_bram_rd_en <= 1'b0;
         case (r_state)
            INIT: begin
               if (i_sequence_numbers_initialized) begin
                  r_state      <= IDLE;
                  r_lan_tready <= 1'b1;
               end
            end
            IDLE: begin
               // Non-PUB beats are consumed here and simply ignored.
               if (from_nb_LAN_tvalid && w_in_type == RPN_MSG_TYPE_LAN_PUB) begin
                  r_state      <= READ_SEQ;
                  r_lan_tready <= 1'b0;
                  r_sender     <= w_in_sender;
                  r_rx_seq     <= w_in_seq;
                  r_app_tdata  <= from_nb_LAN_tdata >> PUB_LAN_DATA_OFF;
                  r_app_tkeep  <= from_nb_LAN_tkeep;
                  r_app_tid    <= from_nb_LAN_tid;
                  r_app_tdest  <= from_nb_LAN_tdest;
                  r_bram_rd_en <= 1'b1;
                  r_bram_addr  <= {{(BRAM_ADDR_WIDTH-NODE_ID_WIDTH-2){1'b0}}, w_in_sender, 2'b00};
               end
            end
            // BRAM sees the read this cycle; DOUT is valid in CHECK.
            READ_SEQ: r_state <= CHECK;
            CHECK: begin
               if (w_diff == {{(SEQ_W-1){1'b0}}, 1'b1}) begin
                  r_state      <= DELIVER;
                  r_new        <= 1'b1;
                  r_app_tvalid <= 1'b1;
               end else if (w_diff == '0 || w_diff[SEQ_W-1]) begin
                  r_state      <= SEND_ACK;
                  r_new        <= 1'b0;
                  r_ack_tvalid <= 1'b1;
                  r_ack_tdata  <= w_ack_tdata;
               end else begin
                  r_state      <= IDLE;
                  r_lan_tready <= 1'b1;
               end
            end
            DELIVER: begin
               if (to_app_tready) begin
                  r_state      <= SEND_ACK;
                  r_app_tvalid <= 1'b0;
                  r_ack_tvalid <= 1'b1;
                  r_ack_tdata  <= w_ack_tdata;
               end
            end
            SEND_ACK: begin
               if (to_nb_ack_tready) begin
                  r_state      <= IDLE;
                  r_ack_tvalid <= 1'b0;
                  r_lan_tready <= 1'b1;
               end
            end
            default: r_state <= INIT;
         endcase
      end
   end

   // Write-back only on the ACK handshake so a reset before the ACK leaves the
   // stored number untouched and the sender's retry is accepted as new.
   assign w_bram_wr = r_ack_tvalid && r_new && to_nb_ack_tready;

   assign from_nb_LAN_tready   = r_lan_tready;
   assign to_app_tvalid        = r_app_tvalid;
   assign to_app_tdata         = r_app_tdata;
   assign to_app_tkeep         = r_app_tkeep;
   assign to_app_tid           = r_app_tid;
   assign to_app_tdest         = r_app_tdest;
   assign to_app_tuser         = r_app_tvalid;
   assign to_app_tlast         = r_app_tvalid;
   assign to_nb_ack_tvalid     = r_ack_tvalid;
   assign to_nb_ack_tdata      = r_ack_tdata;
   assign to_nb_ack_tkeep      = {(AXIS_DATA_WIDTH/8){r_ack_tvalid}};
   assign to_nb_ack_tdest      = r_sender;
   assign to_nb_ack_tuser      = r_ack_tvalid;
   assign to_nb_ack_tlast      = r_ack_tvalid;
   assign rx_seq_num_BRAM_CLK  = i_clk;
   assign rx_seq_num_BRAM_RST  = ~i_ap_rst_n;
   assign rx_seq_num_BRAM_EN   = r_bram_rd_en | w_bram_wr;
   assign rx_seq_num_BRAM_ADDR = r_bram_addr;
   assign rx_seq_num_BRAM_WEN  = {4{w_bram_wr}};
   assign rx_seq_num_BRAM_DIN  = w_bram_wr ? r_rx_seq : '0;

endmodule

// File: tb/tb_rpn_lan_rx.sv
module tb_rpn_lan_rx;
   localparam int         DW     = 512;
   localparam int         KW     = 64;
   localparam logic [7:0] MT_PUB = 8'h10;
   localparam logic [7:0] MT_ACK = 8'h11;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n = 1'b1;
   logic [7:0]    node_id = 8'h42;
   logic          seq_init = 1'b0;
   logic          lan_tvalid = 1'b0, lan_tready;
   logic [DW-1:0] lan_tdata = '0;
   logic [KW-1:0] lan_tkeep = '0;
   logic [7:0]    lan_tid = '0, lan_tdest = '0;
   logic          lan_tuser = 1'b0, lan_tlast = 1'b0;
   logic          app_tvalid, app_tready = 1'b0;
   logic [DW-1:0] app_tdata;
   logic [KW-1:0] app_tkeep;
   logic [7:0]    app_tid, app_tdest;
   logic          app_tuser, app_tlast;
   logic          ack_tvalid, ack_tready = 1'b0;
   logic [DW-1:0] ack_tdata;
   logic [KW-1:0] ack_tkeep;
   logic [7:0]    ack_tdest;
   logic          ack_tuser, ack_tlast;
   logic          bram_clk, bram_rst, bram_en;
   logic [31:0]   bram_addr, bram_din, bram_dout;
   logic [3:0]    bram_wen;

   int vectors = 0, miscompares = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   rpn_lan_rx dut (
      .i_clk(clk), .i_ap_rst_n(rst_n), .i_node_id(node_id),
      .i_sequence_numbers_initialized(seq_init),
      .from_nb_LAN_tvalid(lan_tvalid), .from_nb_LAN_tready(lan_tready),
      .from_nb_LAN_tdata(lan_tdata), .from_nb_LAN_tkeep(lan_tkeep),
      .from_nb_LAN_tid(lan_tid), .from_nb_LAN_tdest(lan_tdest),
      .from_nb_LAN_tuser(lan_tuser), .from_nb_LAN_tlast(lan_tlast),
      .to_app_tvalid(app_tvalid), .to_app_tready(app_tready),
      .to_app_tdata(app_tdata), .to_app_tkeep(app_tkeep),
      .to_app_tid(app_tid), .to_app_tdest(app_tdest),
      .to_app_tuser(app_tuser), .to_app_tlast(app_tlast),
      .to_nb_ack_tvalid(ack_tvalid), .to_nb_ack_tready(ack_tready),
      .to_nb_ack_tdata(ack_tdata), .to_nb_ack_tkeep(ack_tkeep),
      .to_nb_ack_tdest(ack_tdest), .to_nb_ack_tuser(ack_tuser),
      .to_nb_ack_tlast(ack_tlast),
      .rx_seq_num_BRAM_CLK(bram_clk), .rx_seq_num_BRAM_RST(bram_rst),
      .rx_seq_num_BRAM_EN(bram_en), .rx_seq_num_BRAM_ADDR(bram_addr),
      .rx_seq_num_BRAM_DIN(bram_din), .rx_seq_num_BRAM_WEN(bram_wen),
      .rx_seq_num_BRAM_DOUT(bram_dout)
   );

   // BRAM model: one 32-bit word per sender, 1-cycle read latency.
   logic [31:0] mem [0:255];
   logic        pl_en = 1'b0;
   logic [7:0]  pl_idx = '0;
   logic [31:0] pl_val = '0;
   always @(posedge clk) begin
      if (pl_en) mem[pl_idx] <= pl_val;
      else if (bram_en) begin
         if (bram_wen == 4'hF) mem[bram_addr[9:2]] <= bram_din;
         else bram_dout <= mem[bram_addr[9:2]];
      end
   end

   // Reference state: what the BRAM should hold per sender.
   logic [31:0] exp_mem [0:255];

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // 1 = new, 2 = duplicate, 3 = gap; distance taken as a signed 32-bit step.
   function automatic int classify(input logic [31:0] stored, input logic [31:0] seq);
      int dd;
      dd = $signed(seq - stored);
      if (dd == 1) return 1;
      if (dd <= 0) return 2;
      return 3;
   endfunction

   task automatic preload(input logic [7:0] idx, input logic [31:0] val);
      pl_en = 1'b1; pl_idx = idx; pl_val = val; exp_mem[idx] = val;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_lan_tready"}, lan_tready, 0);
      chk({tag, "_app_tvalid"}, app_tvalid, 0);
      chk({tag, "_ack_tvalid"}, ack_tvalid, 0);
      chk({tag, "_app_tdata"}, app_tdata, 0);
      chk({tag, "_ack_tdata"}, ack_tdata, 0);
      chk({tag, "_ack_tkeep"}, ack_tkeep, 0);
      chk({tag, "_bram_en"}, bram_en, 0);
      chk({tag, "_bram_wen"}, bram_wen, 0);
      chk({tag, "_bram_din"}, bram_din, 0);
      chk({tag, "_bram_addr"}, bram_addr, 0);
      chk({tag, "_bram_rst"}, bram_rst, 1);
   endtask

   task automatic run_pkt(input logic [7:0] snd, input logic [31:0] seq,
                          input int app_stall, input int ack_stall, input logic [7:0] mtype);
      logic [DW-1:0] d, eack;
      logic [KW-1:0] kp;
      logic [7:0]    id, dst;
      int kind, a, t, app_wait, ack_wait, app_beats, ack_beats, writes, exp_app, exp_ack, exp_wr;
      logic done;
      for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
      kp = {$urandom, $urandom}; id = 8'($urandom); dst = 8'($urandom);
      d[7:0] = mtype; d[15:8] = snd; d[47:16] = seq;
      kind    = (mtype == MT_PUB) ? classify(exp_mem[snd], seq) : 0;
      exp_app = (kind == 1) ? 1 : 0;
      exp_ack = (kind == 1 || kind == 2) ? 1 : 0;
      exp_wr  = exp_app;
      eack = '0; eack[7:0] = MT_ACK; eack[15:8] = node_id; eack[47:16] = seq;
      t = 0;
      while (!lan_tready && t < 50) begin @(negedge clk); t++; end
      if (!lan_tready) begin chk("lan_tready_timeout", 0, 1); return; end
      lan_tvalid = 1'b1; lan_tdata = d; lan_tkeep = kp; lan_tid = id; lan_tdest = dst;
      a = cyc;
      @(negedge clk);
      lan_tvalid = 1'b0;
      app_wait = 0; ack_wait = 0; app_beats = 0; ack_beats = 0; writes = 0;
      done = 1'b0; t = 0;
      while (!done && t < 200) begin
         if (lan_tready) done = 1'b1;
         else begin
            app_tready = 1'b0; ack_tready = 1'b0;
            if (app_tvalid) begin
               if (app_wait == 0) chk("app_latency", cyc - a, 3);
               chk("app_tdata", app_tdata, d >> 64);
               chk("app_tkeep", app_tkeep, kp);
               chk("app_tid", app_tid, id);
               chk("app_tdest", app_tdest, dst);
               chk("app_tuser_tlast", {app_tuser, app_tlast}, 2'b11);
               app_tready = (app_wait >= app_stall);
               if (app_tready) app_beats++;
               app_wait++;
            end
            if (ack_tvalid) begin
               chk("ack_after_deliver", app_beats, exp_app);
               chk("ack_tdata", ack_tdata, eack);
               chk("ack_tdest", ack_tdest, snd);
               chk("ack_tkeep", ack_tkeep, {KW{1'b1}});
               chk("ack_tuser_tlast", {ack_tuser, ack_tlast}, 2'b11);
               ack_tready = (ack_wait >= ack_stall);
               if (ack_tready) ack_beats++;
               ack_wait++;
            end
            #1;
            if (bram_wen != 4'h0) begin
               writes++;
               chk("wr_wen", bram_wen, 4'hF);
               chk("wr_en", bram_en, 1);
               chk("wr_addr", bram_addr, {22'b0, snd, 2'b00});
               chk("wr_din", bram_din, seq);
               chk("wr_in_ack_hs", ack_tvalid && ack_tready, 1);
            end else chk("din_idle", bram_din, 0);
            @(negedge clk);
            t++;
         end
      end
      if (!done) chk("pkt_timeout", 0, 1);
      app_tready = 1'b0; ack_tready = 1'b0;
      chk("app_beats", app_beats, exp_app);
      chk("ack_beats", ack_beats, exp_ack);
      chk("bram_writes", writes, exp_wr);
      if (exp_wr != 0) exp_mem[snd] = seq;
      chk("bram_contents", mem[snd], exp_mem[snd]);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  s;
      logic [31:0] sq, st;
      logic [DW-1:0] pd;
      int t;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset_outputs("reset");
      chk("bram_clk", bram_clk, clk);
      rst_n = 1'b1;

      // INIT holds off input while sequence numbers are not yet valid.
      pd = '0; pd[7:0] = MT_PUB; pd[15:8] = 8'd3; pd[47:16] = 32'd8;
      lan_tvalid = 1'b1; lan_tdata = pd;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("init_tready", lan_tready, 0);
      end
      lan_tvalid = 1'b0;
      chk("bram_rst_run", bram_rst, 0);
      preload(8'd3, 32'd7);
      preload(8'd5, 32'hFFFF_FFFF);
      preload(8'd6, 32'd0);
      seq_init = 1'b1;
      @(negedge clk);
      chk("init_exit", lan_tready, 1);

      run_pkt(8'd3, 32'd8, 0, 0, MT_PUB);             // new
      run_pkt(8'd3, 32'd8, 0, 1, MT_PUB);             // duplicate
      run_pkt(8'd3, 32'd10, 0, 0, MT_PUB);            // gap
      run_pkt(8'd5, 32'd0, 0, 0, MT_PUB);             // wrap, new
      run_pkt(8'd6, 32'hFFFF_FFFF, 0, 0, MT_PUB);     // wrap, duplicate
      run_pkt(8'd3, 32'd9, 20, 2, MT_PUB);            // long app backpressure
      run_pkt(8'd3, 32'd10, 0, 0, 8'h33);             // non-PUB discarded
      chk("nonpub_idle", lan_tready, 1);

      // Reset while the ACK is pending: no write, INIT until initialized.
      preload(8'd2, 32'd100);
      pd = '0; pd[7:0] = MT_PUB; pd[15:8] = 8'd2; pd[47:16] = 32'd101;
      lan_tvalid = 1'b1; lan_tdata = pd;
      @(negedge clk);
      lan_tvalid = 1'b0; app_tready = 1'b1;
      t = 0;
      while (!ack_tvalid && t < 50) begin @(negedge clk); t++; end
      chk("rst_ack_reached", ack_tvalid, 1);
      rst_n = 1'b0; seq_init = 1'b0; app_tready = 1'b0;
      #1;
      chk_reset_outputs("rst_in_ack");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_init_hold", lan_tready, 0);
      end
      seq_init = 1'b1;
      @(negedge clk);
      chk("rst_resume_idle", lan_tready, 1);
      chk("rst_no_write", mem[2], 32'd100);

      // Randomized traffic.
      for (int i = 0; i < 8; i++) preload(8'(i), $urandom);
      for (int i = 0; i < 40; i++) begin
         s  = 8'($urandom_range(0, 7));
         st = exp_mem[s];
         case ($urandom_range(0, 3))
            0:       sq = st + 32'd1;
            1:       sq = st - 32'($urandom_range(0, 5));
            2:       sq = st + 32'($urandom_range(2, 1000));
            default: sq = $urandom;
         endcase
         run_pkt(s, sq, $urandom_range(0, 3), $urandom_range(0, 3),
                 ($urandom_range(0, 9) == 0) ? 8'h22 : MT_PUB);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
